// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: display data in / multiplexed 7-segment drive out
//   master: drives tick, value, dp_mask, digit_en, lz_en; observes seg, dp, an, frame_start
//   slave : the scanner side, the reverse directions
interface seg7_scan_mux_if;
    logic        tick;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_en;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;
    modport master (output tick, value, dp_mask, digit_en, lz_en,
                    input  seg, dp, an, frame_start);
    modport slave  (input  tick, value, dp_mask, digit_en, lz_en,
                    output seg, dp, an, frame_start);
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: 4-digit common-anode scanner with blanking, zero suppression, frame snapshot
//   CLOCK/RESET : system clock, async active-high reset
//   bus (slave) : tick, value, dp_mask, digit_en, lz_en in; seg, dp, an, frame_start out (active-low drive)
module seg7_scan_mux #(
    parameter int BLANK_CYCLES = 200,
    parameter int CNT_W        = 8
) (
    input  logic           CLOCK,
    input  logic           RESET,
    seg7_scan_mux_if.slave bus
);
    localparam bit               NOBLANK = BLANK_CYCLES == 0;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NOBLANK ? 0 : BLANK_CYCLES - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             idle_q, idle_d;
    logic [15:0]      val_q, val_d;
    logic [3:0]       dpm_q, dpm_d, en_q, en_d;
    logic             lz_q, lz_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d, fs_q, fs_d;
    logic             adv, wrap, load, dis, lz_blank;
    logic [15:0]      sh;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= BLANK;
            idx_q   <= 2'd3;
            cnt_q   <= '0;
            idle_q  <= 1'b1;
            val_q   <= '0;
            dpm_q   <= '0;
            en_q    <= '0;
            lz_q    <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            val_q   <= val_d;
            dpm_q   <= dpm_d;
            en_q    <= en_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end

    // idle_q holds the display dark after reset until the first tick, which
    // starts frame 0 on the zero snapshot without performing a capture.
    always_comb begin
        adv     = bus.tick && (state_q == DRIVE || idle_q);
        wrap    = bus.tick && state_q == DRIVE && idx_q == 2'd3;
        load    = (adv && NOBLANK) || (state_q == BLANK && !idle_q && cnt_q == LAST);
        idx_d   = adv ? idx_q + 2'd1 : idx_q;
        state_d = load ? DRIVE : (adv ? BLANK : state_q);
        cnt_d   = adv ? '0 : (state_q == BLANK && !idle_q ? cnt_q + CNT_W'(1) : cnt_q);
        idle_d  = idle_q && !bus.tick;
        val_d   = wrap ? bus.value    : val_q;
        dpm_d   = wrap ? bus.dp_mask  : dpm_q;
        en_d    = wrap ? bus.digit_en : en_q;
        lz_d    = wrap ? bus.lz_en    : lz_q;
    end

    // Decode from the next-state snapshot/index so a zero-blank wrap shows the fresh capture.
    always_comb begin
        sh       = val_d >> {idx_d, 2'b00};
        dis      = !en_d[idx_d];
        lz_blank = lz_d && idx_d != 2'd0 && sh == 16'h0;
        an_d     = load ? ~(4'b0001 << idx_d) : (adv ? 4'hF : an_q);
        seg_d    = load ? ((dis || lz_blank) ? 7'h7F : hex7(sh[3:0])) : (adv ? 7'h7F : seg_q);
        dp_d     = load ? (dis || !dpm_d[idx_d]) : (adv ? 1'b1 : dp_q);
        fs_d     = load && idx_d == 2'd0;
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: scoreboard bench for seg7_scan_mux at three blank lengths
module tb_seg7_scan_mux;
    localparam int NB [3] = '{4, 10, 0};
    localparam logic [6:0] BL = 7'b1111111, H0 = 7'b1000000, H1 = 7'b1111001,
                           H2 = 7'b0100100, H3 = 7'b0110000, H4 = 7'b0011001,
                           H5 = 7'b0010010, H7 = 7'b1111000, HA = 7'b0001000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        tick;
    logic [15:0] value;
    logic [3:0]  dp_mask, digit_en;
    logic        lz_en;
    logic [3:0]  an_w [3];
    logic [6:0]  seg_w [3];
    logic        dp_w [3];
    logic        fs_w [3];

    seg7_scan_mux_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : gi
        assign bus[g].tick     = tick;
        assign bus[g].value    = value;
        assign bus[g].dp_mask  = dp_mask;
        assign bus[g].digit_en = digit_en;
        assign bus[g].lz_en    = lz_en;
        assign an_w[g]  = bus[g].an;
        assign seg_w[g] = bus[g].seg;
        assign dp_w[g]  = bus[g].dp;
        assign fs_w[g]  = bus[g].frame_start;
        seg7_scan_mux #(.BLANK_CYCLES(NB[g]), .CNT_W(8)) u_dut (
            .CLOCK(CLOCK), .RESET(RESET), .bus(bus[g]));
    end

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        int         blanks;
    } exp_t;

    exp_t       sb [3][$];
    int         vectors = 0, miscompares = 0;
    int         fs_cnt [3] = '{0, 0, 0};
    int         fs_exp [3] = '{0, 0, 0};
    int         off_cnt [3];
    logic [3:0] prev_an [3];

    always @(negedge CLOCK) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (RESET) begin
                prev_an[i] = 4'hF;
                off_cnt[i] = 0;
            end else begin
                if (fs_w[i]) fs_cnt[i]++;
                if (an_w[i] == 4'hF) off_cnt[i]++;
                else if (an_w[i] != prev_an[i]) begin
                    if (sb[i].size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_digit dut%0d an=%b seg=%b", i, an_w[i], seg_w[i]);
                    end else begin
                        e = sb[i].pop_front();
                        vectors++;
                        if (an_w[i] !== e.an || seg_w[i] !== e.seg || dp_w[i] !== e.dp ||
                            fs_w[i] !== e.fs || (e.blanks >= 0 && off_cnt[i] != e.blanks)) begin
                            miscompares++;
                            $display("FAIL digit dut%0d got an=%b seg=%b dp=%b fs=%b off=%0d exp an=%b seg=%b dp=%b fs=%b off=%0d",
                                     i, an_w[i], seg_w[i], dp_w[i], fs_w[i], off_cnt[i],
                                     e.an, e.seg, e.dp, e.fs, e.blanks);
                        end
                    end
                    off_cnt[i] = 0;
                end
                prev_an[i] = an_w[i];
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_reset();
        for (int i = 0; i < 3; i++) begin
            cmp("rst_an", 32'(an_w[i]), 32'hF);
            cmp("rst_seg", 32'(seg_w[i]), 32'h7F);
            cmp("rst_dp", 32'(dp_w[i]), 32'h1);
            cmp("rst_fs", 32'(fs_w[i]), 32'h0);
        end
    endtask

    task automatic push(input int m, input logic [3:0] an, input logic [6:0] seg,
                        input logic dp, input logic fs, input bit after_rst);
        exp_t e;
        for (int i = 0; i < 3; i++)
            if (m[i]) begin
                e.an = an; e.seg = seg; e.dp = dp; e.fs = fs;
                e.blanks = after_rst ? -1 : NB[i];
                sb[i].push_back(e);
                if (fs) fs_exp[i]++;
            end
    endtask

    task automatic pulse();
        @(posedge CLOCK); #1 tick = 1'b1;
        @(posedge CLOCK); #1 tick = 1'b0;
    endtask

    task automatic dig(input int k, input logic [6:0] seg, input logic dp, input bit after_rst);
        push(7, ~(4'b0001 << k), seg, dp, k == 0, after_rst);
        pulse();
        repeat (40) @(posedge CLOCK);
    endtask

    task automatic frame4(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpl);
        dig(0, s0, dpl[0], 0);
        dig(1, s1, dpl[1], 0);
        dig(2, s2, dpl[2], 0);
        dig(3, s3, dpl[3], 0);
    endtask

    initial begin
        tick = 0; value = 0; dp_mask = 0; digit_en = 0; lz_en = 0;
        repeat (3) @(posedge CLOCK);
        #1 chk_reset();
        @(negedge CLOCK) RESET = 1'b0;
        value = 16'h1234; digit_en = 4'hF;
        dig(0, BL, 1'b1, 1);
        dig(1, BL, 1'b1, 0);
        dig(2, BL, 1'b1, 0);
        dig(3, BL, 1'b1, 0);
        frame4(H4, H3, H2, H1, 4'hF);
        value = 16'h0070; lz_en = 1;
        frame4(H0, H7, BL, BL, 4'hF);
        value = 16'h0000;
        frame4(H0, BL, BL, BL, 4'hF);
        value = 16'hAAAA; lz_en = 0;
        dig(0, HA, 1'b1, 0);
        dig(1, HA, 1'b1, 0);
        value = 16'h5555;
        dig(2, HA, 1'b1, 0);
        dig(3, HA, 1'b1, 0);
        frame4(H5, H5, H5, H5, 4'hF);
        digit_en = 4'b1011; dp_mask = 4'b0100;
        frame4(H5, H5, BL, H5, 4'hF);
        value = 16'h0000; lz_en = 1; digit_en = 4'hF; dp_mask = 4'hF;
        frame4(H0, BL, BL, BL, 4'h0);
        value = 16'h1234; lz_en = 0; dp_mask = 4'h0;
        push(7, 4'b1110, H4, 1'b1, 1'b1, 0);
        push(4, 4'b1101, H3, 1'b1, 1'b0, 0);
        @(posedge CLOCK); #1 tick = 1'b1;
        @(posedge CLOCK); #1 tick = 1'b0;
        @(posedge CLOCK);
        @(posedge CLOCK); #1 tick = 1'b1;
        @(posedge CLOCK); #1 tick = 1'b0;
        repeat (6) @(posedge CLOCK);
        @(negedge CLOCK) cmp("blank10_before", 32'(an_w[1]), 32'hF);
        @(negedge CLOCK) cmp("blank10_drive", 32'(an_w[1]), 32'hE);
        repeat (40) @(posedge CLOCK);
        cmp("drop_n10", 32'(an_w[1]), 32'hE);
        cmp("drop_n4", 32'(an_w[0]), 32'hE);
        push(3, 4'b1101, H3, 1'b1, 1'b0, 0);
        push(4, 4'b1011, H2, 1'b1, 1'b0, 0);
        pulse();
        repeat (40) @(posedge CLOCK);
        push(3, 4'b1011, H2, 1'b1, 1'b0, 0);
        push(4, 4'b0111, H1, 1'b1, 1'b0, 0);
        pulse();
        repeat (40) @(posedge CLOCK);
        cmp("pre_rst_an", 32'(an_w[0]), 32'hB);
        @(posedge CLOCK); #3 RESET = 1'b1;
        #1 chk_reset();
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK) RESET = 1'b0;
        push(7, 4'b1110, BL, 1'b1, 1'b1, 1);
        pulse();
        repeat (40) @(posedge CLOCK);
        for (int i = 0; i < 3; i++) begin
            cmp("sb_empty", 32'(sb[i].size()), 32'h0);
            cmp("fs_cycles", 32'(fs_cnt[i]), 32'(fs_exp[i]));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
